instr_reader_exec: RTL



---
 rtl/instr_register_pkg.sv | 12 +
 rtl/instr_reader_exec_if.sv | 31 +++
 rtl/instr_reader_exec.sv | 123 ++++++++++++
 3 files changed

// File: rtl/instr_register_pkg.sv
// Shared instruction-register types: opcode, operand, address and the stored instruction word.
package instr_register_pkg;
  typedef enum logic [2:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;
endpackage

// File: rtl/instr_reader_exec_if.sv
// Control, register-read and result-handshake bundle for instr_reader_exec.
interface instr_reader_exec_if;
  import instr_register_pkg::*;

  logic               start;
  address_t           start_addr;
  logic [5:0]         count;
  address_t           read_pointer;
  instruction_t       instruction_word;
  logic signed [63:0] result;
  opcode_t            result_opc;
  address_t           result_addr;
  logic               result_valid;
  logic               result_ready;
  logic               busy;
  logic               done;
  logic               div_by_zero;

  // master: the reader/executor itself; slave: the register plus stimulus/consumer side
  modport master (
    input  start, start_addr, count, instruction_word, result_ready,
    output read_pointer, result, result_opc, result_addr, result_valid,
           busy, done, div_by_zero
  );

  modport slave (
    output start, start_addr, count, instruction_word, result_ready,
    input  read_pointer, result, result_opc, result_addr, result_valid,
           busy, done, div_by_zero
  );
endinterface

// File: rtl/instr_reader_exec.sv
// Walks a window of the instruction register, executes each entry, presents results on valid/ready.
// Define INSTR_DIV_MOD_EN to build the DIV/MOD divider; otherwise DIV/MOD yield 0.
module instr_reader_exec
  import instr_register_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  instr_reader_exec_if.master bus
);

  // state | meaning
  // IDLE  | waiting for start; window latched on start
  // FETCH | read_pointer drives the register, word captured at edge
  // EXEC  | result computed from captured word
  // OUT   | result_valid high until result_ready
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, OUT, DONE} state_t;

  state_t             state, state_nxt;
  address_t           ptr;
  address_t           rp_hold;
  logic [5:0]         remaining;
  instruction_t       instr_q;
  logic signed [63:0] result_q;
  opcode_t            opc_q;
  address_t           addr_q;
  logic               dbz_q;

  logic signed [63:0] a_ext, b_ext;
  logic signed [63:0] exec_result;
  logic               exec_dbz;
  logic               accept;

  assign accept = (state == OUT) && bus.result_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.count == 6'd0) ? DONE : FETCH;
      FETCH:   state_nxt = EXEC;
      EXEC:    state_nxt = OUT;
      OUT:     if (bus.result_ready) state_nxt = (remaining == 6'd1) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign a_ext = {{32{instr_q.op_a[31]}}, instr_q.op_a};
  assign b_ext = {{32{instr_q.op_b[31]}}, instr_q.op_b};

  // 64-bit operands keep the most-negative / -1 quotient from overflowing
  always_comb begin
    exec_result = '0;
    exec_dbz    = 1'b0;
    case (instr_q.opc)
      ZERO:  exec_result = '0;
      PASSA: exec_result = a_ext;
      PASSB: exec_result = b_ext;
      ADD:   exec_result = a_ext + b_ext;
      SUB:   exec_result = a_ext - b_ext;
      MULT:  exec_result = a_ext * b_ext;
`ifdef INSTR_DIV_MOD_EN
      DIV: begin
        if (b_ext == 64'sd0) exec_dbz    = 1'b1;
        else                 exec_result = a_ext / b_ext;
      end
      MOD: begin
        if (b_ext == 64'sd0) exec_dbz    = 1'b1;
        else                 exec_result = a_ext % b_ext;
      end
`endif
      default: exec_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      rp_hold   <= '0;
      remaining <= '0;
      instr_q   <= '0;
      result_q  <= '0;
      opc_q     <= ZERO;
      addr_q    <= '0;
      dbz_q     <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        ptr       <= bus.start_addr;
        remaining <= bus.count;
      end
      if (state == FETCH) begin
        instr_q <= bus.instruction_word;
        rp_hold <= ptr;
      end
      if (state == EXEC) begin
        result_q <= exec_result;
        dbz_q    <= exec_dbz;
        opc_q    <= instr_q.opc;
        addr_q   <= rp_hold;
      end
      if (accept) begin
        ptr       <= ptr + 5'd1;
        remaining <= remaining - 6'd1;
      end
    end
  end

  // outside FETCH the register sees the last fetched address, not the advanced pointer
  assign bus.read_pointer = (state == FETCH) ? ptr : rp_hold;
  assign bus.result       = result_q;
  assign bus.result_opc   = opc_q;
  assign bus.result_addr  = addr_q;
  assign bus.div_by_zero  = dbz_q;
  assign bus.result_valid = (state == OUT);
  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);

endmodule
